lpc_cycle_decoder: RTL and testbench

//  Passive LPC bus sniffer/decoder, successor to the single-mode I/O-read decoder.

---
 rtl/lpc_pkg.sv | 56 +++++
 rtl/lpc_wait_counter.sv | 40 ++++
 rtl/lpc_cycle_decoder.sv | 182 ++++++++++++++++++
 tb/tb_lpc_cycle_decoder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC decoder types: FSM states, cycle type/dir codes, SYNC codes,
// framing nibbles and build-dependent widths.
// Build option: LPC_MEM_CYCLE_EN enables memory read/write decoding.
package lpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CYCDIR,
    ST_ADDR,
    ST_WDATA,
    ST_TAR,
    ST_SYNC,
    ST_RDATA,
    ST_TAREND
  } lpc_state_e;

  // Cycle type/direction nibble (LPC 1.1); bit 1 is the direction bit
  localparam logic [3:0] CYC_IO_RD  = 4'b0000;
  localparam logic [3:0] CYC_IO_WR  = 4'b0010;
  localparam logic [3:0] CYC_MEM_RD = 4'b0100;
  localparam logic [3:0] CYC_MEM_WR = 4'b0110;

  // SYNC codes
  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;

  // Framing nibbles seen with LFRAME# low
  localparam logic [3:0] LPC_START = 4'b0000;
  localparam logic [3:0] LPC_ABORT = 4'b1111;

`ifdef LPC_MEM_CYCLE_EN
  localparam int unsigned NIB_W     = 3;   // up to 8 address nibbles
  localparam int unsigned ADDR_SH_W = 32;
`else
  localparam int unsigned NIB_W     = 2;   // up to 4 address nibbles
  localparam int unsigned ADDR_SH_W = 16;
`endif

  // I/O cycle: 00xx
  function automatic logic is_io_cyc(input logic [3:0] c);
    return c[3:2] == CYC_IO_RD[3:2];
  endfunction

  // Memory cycle: 01xx
  function automatic logic is_mem_cyc(input logic [3:0] c);
    return c[3:2] == CYC_MEM_RD[3:2];
  endfunction

  // Write direction shares the same bit for I/O and memory
  function automatic logic is_write_cyc(input logic [3:0] c);
    return c[1] == CYC_IO_WR[1] && c[1] == CYC_MEM_WR[1];
  endfunction

endpackage

// File: rtl/lpc_wait_counter.sv
// Counts consecutive wait SYNC nibbles; flags the nibble that brings the
// count up to SYNC_TIMEOUT so the decoder can give up on the same edge.
module lpc_wait_counter #(
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_c_o
);

  localparam int unsigned CNT_W = $clog2(SYNC_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment and saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(SYNC_TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // This wait nibble is the one that reaches SYNC_TIMEOUT
  assign term_c_o = inc_i && !clr_i && (cnt_q == CNT_W'(SYNC_TIMEOUT - 1));

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC sniffer: decodes I/O (and optionally memory) read/write cycles
// and emits one record per completed cycle, plus abort/timeout pulses.
// Build option: LPC_MEM_CYCLE_EN enables memory cycles (8 address nibbles).
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic              lpc_clock,
  input  logic              lpc_reset,
  input  logic [3:0]        lpc_ad,
  input  logic              lpc_frame,
  output logic [3:0]        out_cyctype_dir,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic              out_sync_err,
  output logic              out_valid,
  output logic              out_sync_timeout,
  output logic              out_abort
);

`ifdef LPC_MEM_CYCLE_EN
  if (ADDR_W < 32) begin : g_addr_w_check
    $error("lpc_cycle_decoder: memory cycles need ADDR_W >= 32");
  end
`endif

  lpc_state_e           state_q;
  logic [NIB_W-1:0]     nib_q;       // nibbles remaining in current phase, minus one
  logic [3:0]           cyc_q;
  logic [ADDR_SH_W-1:0] addr_sh_q;
  logic [7:0]           data_sh_q;
  logic                 err_sh_q;

  logic wait_inc_c;
  logic wait_clr_c;
  logic wait_term_c;

  // Wait nibbles only count while sitting in SYNC with the frame still open
  assign wait_inc_c = (state_q == ST_SYNC) && lpc_frame &&
                      ((lpc_ad == SYNC_SHORT_WAIT) || (lpc_ad == SYNC_LONG_WAIT));
  assign wait_clr_c = (state_q != ST_SYNC);

  lpc_wait_counter #(
    .SYNC_TIMEOUT (SYNC_TIMEOUT)
  ) u_wait_counter (
    .clk_i    (lpc_clock),
    .rst_ni   (lpc_reset),
    .clr_i    (wait_clr_c),
    .inc_i    (wait_inc_c),
    .term_c_o (wait_term_c)
  );

  // Cycle FSM with shadow capture; record outputs load only on completion
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q          <= ST_IDLE;
      nib_q            <= '0;
      cyc_q            <= '0;
      addr_sh_q        <= '0;
      data_sh_q        <= '0;
      err_sh_q         <= 1'b0;
      out_cyctype_dir  <= '0;
      out_addr         <= '0;
      out_data         <= '0;
      out_sync_err     <= 1'b0;
      out_valid        <= 1'b0;
      out_sync_timeout <= 1'b0;
      out_abort        <= 1'b0;
    end else begin
      out_valid        <= 1'b0;
      out_sync_timeout <= 1'b0;
      out_abort        <= 1'b0;

      if (!lpc_frame) begin
        if (lpc_ad == LPC_START) begin
          state_q <= ST_CYCDIR;
        end else begin
          if ((lpc_ad == LPC_ABORT) && (state_q != ST_IDLE)) begin
            out_abort <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_IDLE: ;

          ST_CYCDIR: begin
            cyc_q     <= lpc_ad;
            addr_sh_q <= '0;
            err_sh_q  <= 1'b0;
            if (is_io_cyc(lpc_ad)) begin
              state_q <= ST_ADDR;
              nib_q   <= NIB_W'(3);
            end
`ifdef LPC_MEM_CYCLE_EN
            else if (is_mem_cyc(lpc_ad)) begin
              state_q <= ST_ADDR;
              nib_q   <= NIB_W'(7);
            end
`endif
            else begin
              state_q <= ST_IDLE;
            end
          end

          ST_ADDR: begin
            addr_sh_q <= {addr_sh_q[ADDR_SH_W-5:0], lpc_ad};
            if (nib_q == '0) begin
              state_q <= is_write_cyc(cyc_q) ? ST_WDATA : ST_TAR;
              nib_q   <= NIB_W'(1);
            end else begin
              nib_q <= nib_q - NIB_W'(1);
            end
          end

          ST_WDATA: begin
            data_sh_q <= {lpc_ad, data_sh_q[7:4]};
            if (nib_q == '0) begin
              state_q <= ST_TAR;
              nib_q   <= NIB_W'(1);
            end else begin
              nib_q <= nib_q - NIB_W'(1);
            end
          end

          ST_TAR: begin
            if (nib_q == '0) begin
              state_q <= ST_SYNC;
            end else begin
              nib_q <= nib_q - NIB_W'(1);
            end
          end

          ST_SYNC: begin
            case (lpc_ad)
              SYNC_READY, SYNC_ERROR: begin
                err_sh_q <= (lpc_ad == SYNC_ERROR);
                state_q  <= is_write_cyc(cyc_q) ? ST_TAREND : ST_RDATA;
                nib_q    <= NIB_W'(1);
              end
              SYNC_SHORT_WAIT, SYNC_LONG_WAIT: begin
                if (wait_term_c) begin
                  state_q          <= ST_IDLE;
                  out_sync_timeout <= 1'b1;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end

          ST_RDATA: begin
            data_sh_q <= {lpc_ad, data_sh_q[7:4]};
            if (nib_q == '0) begin
              state_q <= ST_TAREND;
              nib_q   <= NIB_W'(1);
            end else begin
              nib_q <= nib_q - NIB_W'(1);
            end
          end

          ST_TAREND: begin
            if (nib_q == '0) begin
              state_q         <= ST_IDLE;
              out_valid       <= 1'b1;
              out_cyctype_dir <= cyc_q;
              out_addr        <= ADDR_W'(addr_sh_q);
              out_data        <= data_sh_q;
              out_sync_err    <= err_sh_q;
            end else begin
              nib_q <= nib_q - NIB_W'(1);
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Self-checking bench for lpc_cycle_decoder: directed vector table, a reset
// sequence, then randomized transactions with expectations built per cycle.
module tb_lpc_cycle_decoder;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TO     = 4;
  localparam int unsigned NTRANS = 300;

  logic              lpc_clock = 1'b0;
  logic              lpc_reset;
  logic [3:0]        lpc_ad;
  logic              lpc_frame;
  logic [3:0]        out_cyctype_dir;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        out_data;
  logic              out_sync_err;
  logic              out_valid;
  logic              out_sync_timeout;
  logic              out_abort;

  lpc_cycle_decoder #(
    .ADDR_W       (ADDR_W),
    .SYNC_TIMEOUT (TO)
  ) dut (
    .lpc_clock        (lpc_clock),
    .lpc_reset        (lpc_reset),
    .lpc_ad           (lpc_ad),
    .lpc_frame        (lpc_frame),
    .out_cyctype_dir  (out_cyctype_dir),
    .out_addr         (out_addr),
    .out_data         (out_data),
    .out_sync_err     (out_sync_err),
    .out_valid        (out_valid),
    .out_sync_timeout (out_sync_timeout),
    .out_abort        (out_abort)
  );

  always #15 lpc_clock = ~lpc_clock;

  typedef struct {
    logic        f;
    logic [3:0]  ad;
    logic        v;
    logic        t;
    logic        a;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [3:0]  cyc;
    logic        err;
  } vec_t;

  typedef struct {
    logic       f;
    logic [3:0] ad;
  } nib_t;

  vec_t  vq[$];
  nib_t  seg[$];
  string tag;

  // Expected held record fields
  logic [31:0] r_addr;
  logic [7:0]  r_data;
  logic [3:0]  r_cyc;
  logic        r_err;
  logic [3:0]  g_cyc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " valid"},   32'(out_valid), 32'd0);
    chk({name, " timeout"}, 32'(out_sync_timeout), 32'd0);
    chk({name, " abort"},   32'(out_abort), 32'd0);
    chk({name, " addr"},    out_addr, 32'd0);
    chk({name, " data"},    32'(out_data), 32'd0);
    chk({name, " cyctype"}, 32'(out_cyctype_dir), 32'd0);
    chk({name, " sync_err"}, 32'(out_sync_err), 32'd0);
  endtask

  task automatic add_row(input logic f, input logic [3:0] ad,
                         input logic v, input logic t, input logic a);
    vq.push_back('{f, ad, v, t, a, r_addr, r_data, r_cyc, r_err});
  endtask

  task automatic add_vld(input logic f, input logic [3:0] ad, input logic [31:0] addr,
                         input logic [7:0] data, input logic [3:0] cyc, input logic err);
    r_addr = addr;
    r_data = data;
    r_cyc  = cyc;
    r_err  = err;
    add_row(f, ad, 1'b1, 1'b0, 1'b0);
  endtask

  // Drive each row for one clock and compare #1 after the edge
  task automatic run_vectors();
    foreach (vq[i]) begin
      lpc_frame = vq[i].f;
      lpc_ad    = vq[i].ad;
      @(posedge lpc_clock);
      #1;
      chk($sformatf("%s/%0d valid", tag, i),    32'(out_valid),        32'(vq[i].v));
      chk($sformatf("%s/%0d timeout", tag, i),  32'(out_sync_timeout), 32'(vq[i].t));
      chk($sformatf("%s/%0d abort", tag, i),    32'(out_abort),        32'(vq[i].a));
      chk($sformatf("%s/%0d addr", tag, i),     out_addr,              vq[i].addr);
      chk($sformatf("%s/%0d data", tag, i),     32'(out_data),         32'(vq[i].data));
      chk($sformatf("%s/%0d cyctype", tag, i),  32'(out_cyctype_dir),  32'(vq[i].cyc));
      chk($sformatf("%s/%0d sync_err", tag, i), 32'(out_sync_err),     32'(vq[i].err));
    end
    vq.delete();
  endtask

  // START(s), type nibble, address MSB first, write data, two TAR nibbles
  task automatic gen_prefix(input bit mem, input bit wr, input logic [31:0] addr,
                            input logic [7:0] data, input bit dbl);
    int n;
    seg.delete();
    if (dbl) seg.push_back('{1'b0, 4'h0});
    seg.push_back('{1'b0, 4'h0});
    g_cyc = {1'b0, mem, wr, 1'($urandom_range(0, 1))};
    seg.push_back('{1'b1, g_cyc});
    n = mem ? 8 : 4;
    for (int k = n - 1; k >= 0; k--) seg.push_back('{1'b1, addr[4*k +: 4]});
    if (wr) begin
      seg.push_back('{1'b1, data[3:0]});
      seg.push_back('{1'b1, data[7:4]});
    end
    for (int k = 0; k < 2; k++) seg.push_back('{1'b1, 4'($urandom_range(0, 15))});
  endtask

  task automatic push_wait();
    seg.push_back('{1'b1, ($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6});
  endtask

  // Waits, final SYNC, read data, two TAR-end nibbles
  task automatic gen_tail(input bit wr, input logic [7:0] data, input int waits, input bit err);
    for (int k = 0; k < waits; k++) push_wait();
    seg.push_back('{1'b1, err ? 4'hA : 4'h0});
    if (!wr) begin
      seg.push_back('{1'b1, data[3:0]});
      seg.push_back('{1'b1, data[7:4]});
    end
    for (int k = 0; k < 2; k++) seg.push_back('{1'b1, 4'($urandom_range(0, 15))});
  endtask

  task automatic emit_quiet(input int upto);
    for (int k = 0; k < upto; k++) add_row(seg[k].f, seg[k].ad, 1'b0, 1'b0, 1'b0);
  endtask

  // Idle filler; bus is idle so nothing may be reported
  task automatic gen_gap();
    int n;
    n = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) != 0) add_row(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
      else                           add_row(1'b0, 4'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic random_trans(input int idx);
    int          kind;
    int          sel;
    int          p;
    bit          mem;
    bit          wr;
    bit          err;
    bit          gap_ok;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [3:0]  bad;

    kind   = $urandom_range(0, 8);
    mem    = (kind == 5);
    wr     = ($urandom_range(0, 1) != 0);
    err    = ($urandom_range(0, 3) == 0);
    addr   = $urandom;
    data   = 8'($urandom);
    gap_ok = 1'b1;
    tag    = $sformatf("rand%0d.k%0d", idx, kind);

    if (kind <= 5) begin
      gen_prefix(mem, wr, addr, data, ($urandom_range(0, 3) == 0));
`ifndef LPC_MEM_CYCLE_EN
      if (mem) begin
        // Memory cycles are unsupported: decoder drops back to idle after the type nibble
        p = (seg[1].f == 1'b0) ? 3 : 2;
        emit_quiet(p);
        run_vectors();
        gen_gap();
        run_vectors();
        return;
      end
`endif
      gen_tail(wr, data, $urandom_range(0, TO - 1), err);
      sel = $urandom_range(0, 9);
      p   = $urandom_range(1, seg.size() - 1);
      if (sel == 0) begin
        emit_quiet(p);
        add_row(1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
      end else if (sel == 1) begin
        emit_quiet(p);
        gap_ok = 1'b0;
      end else begin
        emit_quiet(seg.size() - 1);
        add_vld(seg[seg.size()-1].f, seg[seg.size()-1].ad,
                mem ? addr : {16'h0, addr[15:0]}, data, g_cyc, err);
      end
    end else if (kind == 6) begin
      gen_prefix(1'b0, wr, addr, data, 1'b0);
      emit_quiet(seg.size());
      for (int k = 0; k < TO; k++)
        add_row(1'b1, ($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6, 1'b0, (k == TO - 1), 1'b0);
    end else if (kind == 7) begin
      gen_prefix(1'b0, wr, addr, data, 1'b0);
      for (int k = 0; k < $urandom_range(0, TO - 1); k++) push_wait();
      do bad = 4'($urandom_range(0, 15));
      while (bad == 4'h0 || bad == 4'h5 || bad == 4'h6 || bad == 4'hA);
      seg.push_back('{1'b1, bad});
      for (int k = 0; k < 3; k++) seg.push_back('{1'b1, 4'($urandom_range(0, 15))});
      emit_quiet(seg.size());
    end else begin
      add_row(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      add_row(1'b1, {1'b1, 3'($urandom_range(0, 7))}, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) add_row(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    end
    if (gap_ok) gen_gap();
    run_vectors();
  endtask

  initial begin
    r_addr    = '0;
    r_data    = '0;
    r_cyc     = '0;
    r_err     = 1'b0;
    lpc_reset = 1'b0;
    lpc_frame = 1'b1;
    lpc_ad    = 4'h0;
    repeat (2) @(posedge lpc_clock);
    #1;
    chk_zero("reset");
    lpc_reset = 1'b1;

    // Directed table
    tag = "dir";
    add_row(1, 4'h3, 0, 0, 0);
    add_row(0, 4'h5, 0, 0, 0);
    // I/O read 0x0080, data 0xA5
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h8, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h5, 0, 0, 0);
    add_row(1, 4'hA, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
    add_vld(1, 4'hF, 32'h0000_0080, 8'hA5, 4'h0, 1'b0);
    add_row(1, 4'h0, 0, 0, 0);
    // I/O write 0x002E, data 0x3C, three short waits
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h2, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h2, 0, 0, 0); add_row(1, 4'hE, 0, 0, 0);
    add_row(1, 4'hC, 0, 0, 0); add_row(1, 4'h3, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
    add_row(1, 4'h5, 0, 0, 0); add_row(1, 4'h5, 0, 0, 0);
    add_row(1, 4'h5, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0);
    add_vld(1, 4'hF, 32'h0000_002E, 8'h3C, 4'h2, 1'b0);
    // I/O read 0x1234 completing with SYNC error, data 0x7E
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h1, 0, 0, 0); add_row(1, 4'h2, 0, 0, 0);
    add_row(1, 4'h3, 0, 0, 0); add_row(1, 4'h4, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'hA, 0, 0, 0); add_row(1, 4'hE, 0, 0, 0);
    add_row(1, 4'h7, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_vld(1, 4'h0, 32'h0000_1234, 8'h7E, 4'h0, 1'b1);
    // Timeout after four long waits; fields hold
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h6, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
    add_row(1, 4'h6, 0, 0, 0); add_row(1, 4'h6, 0, 0, 0);
    add_row(1, 4'h6, 0, 0, 0); add_row(1, 4'h6, 0, 1, 0);
    add_row(1, 4'h0, 0, 0, 0);
    // Next cycle decodes normally: I/O write 0x0061, data 0x01
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h2, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h6, 0, 0, 0); add_row(1, 4'h1, 0, 0, 0);
    add_row(1, 4'h1, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_vld(1, 4'h0, 32'h0000_0061, 8'h01, 4'h2, 1'b0);
    // Abort during address phase; fields hold
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h4, 0, 0, 0); add_row(1, 4'h5, 0, 0, 0);
    add_row(0, 4'hF, 0, 0, 1); add_row(1, 4'h0, 0, 0, 0);
    // Abort code while idle is not an abort
    add_row(0, 4'hF, 0, 0, 0);
    // Non-target START mid-cycle drops it silently
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h1, 0, 0, 0); add_row(0, 4'h7, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    // Memory read 0xFFFFFFF0, data 0x5A
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h4, 0, 0, 0);
    for (int k = 0; k < 7; k++) add_row(1, 4'hF, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'hA, 0, 0, 0);
    add_row(1, 4'h5, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
`ifdef LPC_MEM_CYCLE_EN
    add_vld(1, 4'hF, 32'hFFFF_FFF0, 8'h5A, 4'h4, 1'b0);
`else
    add_row(1, 4'hF, 0, 0, 0);
`endif
    add_row(1, 4'h0, 0, 0, 0);
    run_vectors();

    // Reset in the middle of read data phase
    tag = "rst";
    add_row(0, 4'h0, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h3, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0); add_row(1, 4'h8, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
    add_row(1, 4'h0, 0, 0, 0); add_row(1, 4'h9, 0, 0, 0);
    run_vectors();
    lpc_reset = 1'b0;
    #1;
    chk_zero("rst async");
    @(posedge lpc_clock);
    #1;
    chk_zero("rst held");
    lpc_reset = 1'b1;
    r_addr = '0;
    r_data = '0;
    r_cyc  = '0;
    r_err  = 1'b0;
    add_row(1, 4'h2, 0, 0, 0); add_row(1, 4'hF, 0, 0, 0);
    add_row(1, 4'hF, 0, 0, 0); add_row(1, 4'h0, 0, 0, 0);
    run_vectors();

    // Randomized transactions
    for (int n = 0; n < NTRANS; n++) random_trans(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
